// File: rtl/bus_if_pkg.sv
// Shared definitions for the MEM-stage bus master: memory op codes,
// FSM state encodings, bus direction and active-low strobe levels.
package bus_if_pkg;

  localparam int MEM_OP_W    = 2;
  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 2'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LDW = 2'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_STW = 2'd2;

  // Bus direction as driven on bus_rw
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Levels for active-low bus strobes
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Level of the reset input that holds the block in reset
  localparam logic RESET_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    BUS_IF_IDLE   = 2'd0,
    BUS_IF_REQ    = 2'd1,
    BUS_IF_ACCESS = 2'd2,
    BUS_IF_STALL  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_if.sv
// MEM-stage bus master. Converts an EX/MEM load/store into a
// request/grant/strobe/ready bus transaction, stalls the pipeline while the
// transaction is outstanding and muxes the MEM-stage result.
module bus_if
  import bus_if_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                ex_en,
  input  logic [MEM_OP_W-1:0] ex_mem_op,
  input  logic [DATA_W-1:0]   ex_mem_wr_data,
  input  logic [DATA_W-1:0]   ex_out,
  output logic [DATA_W-1:0]   out,
  output logic                miss_align,
  output logic                busy,
  output logic                bus_req_,
  input  logic                bus_grnt_,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_as_,
  output logic                bus_rw,
  output logic [DATA_W-1:0]   bus_wr_data,
  input  logic [DATA_W-1:0]   bus_rd_data,
  input  logic                bus_rdy_
);

  bus_state_e          state_q;
  bus_state_e          state_d;
  logic [DATA_W-1:0]   rd_buf;
  logic                access;
  logic                mis;
  logic                launch;
  logic                rdy;
  logic [DATA_W-1:0]   rd_result;

  // A flushed EX entry never starts a bus access; op 3 decodes as NOP.
  assign access = ex_en & ((ex_mem_op == MEM_OP_LDW) | (ex_mem_op == MEM_OP_STW)) & ~flush;
  assign mis    = access & (ex_out[1:0] != 2'b00);
  assign launch = access & ~mis;
  assign rdy    = (bus_rdy_ == ENABLE_);
  // bus_rw is held for the whole transaction, so it tells a load from a store.
  assign rd_result = (bus_rw == READ) ? bus_rd_data : '0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_q <= BUS_IF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the combinational result mux and stall request
  always_comb begin
    state_d    = state_q;
    out        = ex_out;
    miss_align = 1'b0;
    busy       = 1'b0;
    case (state_q)
      BUS_IF_IDLE: begin
        if (mis) begin
          miss_align = 1'b1;
          out        = '0;
        end else if (access) begin
          busy    = 1'b1;
          state_d = BUS_IF_REQ;
        end
      end
      BUS_IF_REQ: begin
        busy = 1'b1;
        if (bus_grnt_ == ENABLE_) begin
          state_d = BUS_IF_ACCESS;
        end
      end
      BUS_IF_ACCESS: begin
        if (rdy) begin
          out     = rd_result;
          state_d = stall ? BUS_IF_STALL : BUS_IF_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      BUS_IF_STALL: begin
        out = rd_buf;
        if (!stall) begin
          state_d = BUS_IF_IDLE;
        end
      end
      default: state_d = BUS_IF_IDLE;
    endcase
  end

  // Registered bus outputs and the read buffer that survives a pipeline stall
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      case (state_q)
        BUS_IF_IDLE: begin
          if (launch) begin
            bus_req_    <= ENABLE_;
            bus_addr    <= ex_out[ADDR_W+1:2];
            bus_rw      <= (ex_mem_op == MEM_OP_LDW) ? READ : WRITE;
            bus_wr_data <= ex_mem_wr_data;
          end
        end
        BUS_IF_REQ: begin
          if (bus_grnt_ == ENABLE_) begin
            bus_as_ <= ENABLE_;
          end
        end
        BUS_IF_ACCESS: begin
          bus_as_ <= DISABLE_;
          if (rdy) begin
            rd_buf   <= rd_result;
            bus_req_ <= DISABLE_;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_if.sv
// Directed bench for the MEM-stage bus master.
module tb_bus_if;
  import bus_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_en;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [31:0] ex_out;
  logic [31:0] out;
  logic        miss_align;
  logic        busy;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  int n_chk = 0;
  int n_err = 0;

  bus_if #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_en(ex_en),
    .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out),
    .out(out), .miss_align(miss_align), .busy(busy), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; ex_en = 1'b0; ex_mem_op = 2'd0;
    ex_mem_wr_data = '0; ex_out = 32'h0000_0055; bus_grnt_ = 1'b1;
    bus_rd_data = '0; bus_rdy_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus_req_), 32'd1);
    chk("rst_as", 32'(bus_as_), 32'd1);
    chk("rst_rw", 32'(bus_rw), 32'd1);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_wdata", bus_wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", out, 32'h0000_0055);
    chk("rst_state", 32'(dut.state_q), 32'(BUS_IF_IDLE));
    reset = 1'b1;
    tick();

    // LDW, grant and ready one cycle after each step
    ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h0000_0104;
    #1;
    chk("t1_busy_idle", 32'(busy), 32'd1);
    chk("t1_miss", 32'(miss_align), 32'd0);
    tick();
    chk("t1_req", 32'(bus_req_), 32'd0);
    chk("t1_addr", 32'(bus_addr), 32'h41);
    chk("t1_rw", 32'(bus_rw), 32'd1);
    chk("t1_as_req", 32'(bus_as_), 32'd1);
    chk("t1_busy_req", 32'(busy), 32'd1);
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    #1;
    chk("t1_as_low", 32'(bus_as_), 32'd0);
    chk("t1_busy_acc", 32'(busy), 32'd1);
    tick();
    chk("t1_as_high", 32'(bus_as_), 32'd1);
    bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
    #1;
    chk("t1_busy_rdy", 32'(busy), 32'd0);
    chk("t1_out", out, 32'hDEAD_BEEF);
    tick();
    ex_en = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = '0; ex_out = 32'h0;
    #1;
    chk("t1_req_done", 32'(bus_req_), 32'd1);
    chk("t1_state", 32'(dut.state_q), 32'(BUS_IF_IDLE));

    // STW, grant delayed 4 cycles (with a stray ready in REQ), ready delayed 2
    ex_en = 1'b1; ex_mem_op = 2'd2; ex_out = 32'h0000_0200; ex_mem_wr_data = 32'h1234_5678;
    #1;
    chk("t2_busy_idle", 32'(busy), 32'd1);
    tick();
    ex_mem_wr_data = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      bus_rdy_ = (i == 2) ? 1'b0 : 1'b1;
      #1;
      chk("t2_req_wait", 32'(bus_req_), 32'd0);
      chk("t2_rw", 32'(bus_rw), 32'd0);
      chk("t2_wdata_req", bus_wr_data, 32'h1234_5678);
      chk("t2_as_req", 32'(bus_as_), 32'd1);
      chk("t2_busy_req", 32'(busy), 32'd1);
      tick();
    end
    chk("t2_still_req", 32'(dut.state_q), 32'(BUS_IF_REQ));
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    #1;
    chk("t2_as_low", 32'(bus_as_), 32'd0);
    for (int j = 0; j < 2; j++) begin
      chk("t2_busy_acc", 32'(busy), 32'd1);
      chk("t2_wdata_acc", bus_wr_data, 32'h1234_5678);
      chk("t2_addr_acc", 32'(bus_addr), 32'h80);
      tick();
    end
    bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFF_FFFF;
    #1;
    chk("t2_out", out, 32'h0);
    chk("t2_busy_rdy", 32'(busy), 32'd0);
    tick();
    ex_en = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = '0;
    #1;
    chk("t2_req_done", 32'(bus_req_), 32'd1);
    chk("t2_rdbuf", dut.rd_buf, 32'h0);
    chk("t2_state", 32'(dut.state_q), 32'(BUS_IF_IDLE));

    // Misaligned LDW
    ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h0000_0102;
    #1;
    chk("t3_miss", 32'(miss_align), 32'd1);
    chk("t3_out", out, 32'h0);
    chk("t3_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_req", 32'(bus_req_), 32'd1);
    chk("t3_state", 32'(dut.state_q), 32'(BUS_IF_IDLE));

    // Non-memory ops (NOP and op 3) pass ex_out through
    ex_mem_op = 2'd0; ex_out = 32'hCAFE_0001;
    #1;
    chk("t4_out", out, 32'hCAFE_0001);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_miss", 32'(miss_align), 32'd0);
    tick();
    chk("t4_req", 32'(bus_req_), 32'd1);
    ex_mem_op = 2'd3; ex_out = 32'h0000_0200;
    #1;
    chk("t4_op3_out", out, 32'h0000_0200);
    chk("t4_op3_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_op3_req", 32'(bus_req_), 32'd1);
    ex_en = 1'b0;

    // LDW completing under a 3-cycle stall
    ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h0000_0300;
    tick();
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    tick();
    bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_A5A5; stall = 1'b1;
    #1;
    chk("t5_out_rdy", out, 32'hA5A5_A5A5);
    chk("t5_busy_rdy", 32'(busy), 32'd0);
    tick();
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    #1;
    chk("t5_state", 32'(dut.state_q), 32'(BUS_IF_STALL));
    chk("t5_out_s1", out, 32'hA5A5_A5A5);
    chk("t5_busy_s1", 32'(busy), 32'd0);
    chk("t5_req_s1", 32'(bus_req_), 32'd1);
    tick();
    chk("t5_out_s2", out, 32'hA5A5_A5A5);
    stall = 1'b0;
    #1;
    chk("t5_out_s3", out, 32'hA5A5_A5A5);
    tick();
    ex_en = 1'b0;
    #1;
    chk("t5_idle", 32'(dut.state_q), 32'(BUS_IF_IDLE));
    chk("t5_out_idle", out, 32'h0000_0300);

    // Reset asserted in ACCESS
    ex_en = 1'b1; ex_mem_op = 2'd2; ex_out = 32'h0000_0400; ex_mem_wr_data = 32'hCAFE_BABE;
    tick();
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    #1;
    chk("t6_in_access", 32'(dut.state_q), 32'(BUS_IF_ACCESS));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_req", 32'(bus_req_), 32'd1);
    chk("t6_as", 32'(bus_as_), 32'd1);
    chk("t6_rw", 32'(bus_rw), 32'd1);
    chk("t6_addr", 32'(bus_addr), 32'd0);
    chk("t6_wdata", bus_wr_data, 32'd0);
    chk("t6_state", 32'(dut.state_q), 32'(BUS_IF_IDLE));
    ex_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Flush during REQ does not abort the access
    ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h0000_0500;
    tick();
    flush = 1'b1;
    #1;
    chk("t7_busy_req", 32'(busy), 32'd1);
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    tick();
    bus_rdy_ = 1'b0; bus_rd_data = 32'h1357_9BDF;
    #1;
    chk("t7_out", out, 32'h1357_9BDF);
    chk("t7_busy_rdy", 32'(busy), 32'd0);
    tick();
    flush = 1'b0; ex_en = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = '0;
    #1;
    chk("t7_state", 32'(dut.state_q), 32'(BUS_IF_IDLE));

    // Flush in IDLE blocks a new LDW (and masks misalignment)
    flush = 1'b1; ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h0000_0600;
    #1;
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_out", out, 32'h0000_0600);
    tick();
    chk("t8_req", 32'(bus_req_), 32'd1);
    chk("t8_state", 32'(dut.state_q), 32'(BUS_IF_IDLE));
    ex_out = 32'h0000_0602;
    #1;
    chk("t8_miss", 32'(miss_align), 32'd0);
    flush = 1'b0; ex_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
